bomb_manager: RTL and testbench



---
 rtl/bomberman_pkg.sv | 28 ++
 rtl/bomb_slot.sv | 98 +++++++++
 rtl/bomb_manager.sv | 155 +++++++++++++++
 tb/tb_bomb_manager.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and widths for the bomb manager and its per-slot FSM.
// The blast-cross test lives here so every slot comparison uses one definition.
package bomberman_pkg;

    localparam int COORD_W = 4;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_FUSE  = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_e;

    // True when tile (px,py) lies on the plus-shaped blast centred on (bx,by).
    function automatic logic in_cross(input logic [COORD_W-1:0] bx,
                                      input logic [COORD_W-1:0] by,
                                      input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py);
        int dx;
        int dy;
        dx = int'(bx) - int'(px);
        dy = int'(by) - int'(py);
        return ((dx == 0) && (dy >= -1) && (dy <= 1)) ||
               ((dy == 0) && (dx >= -1) && (dx <= 1));
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE -> FUSE -> BLAST -> FREE, aged by the frame tick.
// detonate_o pulses on the tick that moves the slot from FUSE into BLAST.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS  = 8,
    parameter int BLAST_TICKS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               tick_i,
    input  logic               alloc_i,
    input  logic               owner_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output slot_state_e        state_o,
    output logic               owner_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               detonate_o
);

    slot_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               owner_q, owner_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_FREE;
            timer_q <= '0;
            owner_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        owner_d    = owner_q;
        x_d        = x_q;
        y_d        = y_q;
        detonate_o = 1'b0;
        if (clear_i) begin
            state_d = SLOT_FREE;
            timer_d = '0;
        end else begin
            case (state_q)
                SLOT_FREE: begin
                    // A fresh bomb is never aged by a tick in its placement cycle.
                    if (alloc_i) begin
                        state_d = SLOT_FUSE;
                        timer_d = TIMER_W'(FUSE_TICKS - 1);
                        owner_d = owner_i;
                        x_d     = x_i;
                        y_d     = y_i;
                    end
                end
                SLOT_FUSE: begin
                    if (tick_i) begin
                        if (timer_q == '0) begin
                            state_d    = SLOT_BLAST;
                            timer_d    = TIMER_W'(BLAST_TICKS - 1);
                            detonate_o = 1'b1;
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                end
                SLOT_BLAST: begin
                    if (tick_i) begin
                        if (timer_q == '0) state_d = SLOT_FREE;
                        else               timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = SLOT_FREE;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign owner_o = owner_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/bomb_manager.sv
// Bomb slot pool and player lives: placement arbitration, blast damage,
// and a combinational per-slot read port for the draw loop.
module bomb_manager
    import bomberman_pkg::*;
#(
    parameter int NUM_BOMBS      = 6,
    parameter int MAX_PER_PLAYER = 3,
    parameter int FUSE_TICKS     = 8,
    parameter int BLAST_TICKS    = 2,
    parameter int START_LIVES    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_reset,
    input  logic               tick,
    input  logic               read_input,
    input  logic               p1_place,
    input  logic               p2_place,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic [2:0]         bomb_id,
    output logic               bomb_active,
    output logic               bomb_exploding,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic [LIVES_W-1:0] p1_lives,
    output logic [LIVES_W-1:0] p2_lives
);

    localparam logic [LIVES_W-1:0] START_L = LIVES_W'(START_LIVES);

    slot_state_e          slot_state [NUM_BOMBS];
    logic                 slot_owner [NUM_BOMBS];
    logic [COORD_W-1:0]   slot_x     [NUM_BOMBS];
    logic [COORD_W-1:0]   slot_y     [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] slot_det;
    logic [NUM_BOMBS-1:0] alloc1, alloc2;

    int   cnt1, cnt2, first_free, second_free;
    logic busy1, busy2, same_tile;
    logic p1_ok, p2_ok, game_over, hit1, hit2;

    logic [LIVES_W-1:0] p1_lives_q, p1_lives_d;
    logic [LIVES_W-1:0] p2_lives_q, p2_lives_d;

    assign game_over = (p1_lives_q == '0) || (p2_lives_q == '0);

    always_comb begin
        cnt1        = 0;
        cnt2        = 0;
        first_free  = -1;
        second_free = -1;
        busy1       = 1'b0;
        busy2       = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (slot_state[i] == SLOT_FREE) begin
                if (first_free < 0)       first_free  = i;
                else if (second_free < 0) second_free = i;
            end else begin
                if (slot_owner[i]) cnt2++;
                else               cnt1++;
                if (slot_x[i] == p1_x && slot_y[i] == p1_y) busy1 = 1'b1;
                if (slot_x[i] == p2_x && slot_y[i] == p2_y) busy2 = 1'b1;
            end
        end
        same_tile = (p1_x == p2_x) && (p1_y == p2_y);
        p1_ok = read_input && p1_place && !game_over && (cnt1 < MAX_PER_PLAYER) &&
                !busy1 && (first_free >= 0);
        // P1 wins the lowest slot; P2 falls to the next one and yields a shared tile.
        p2_ok = read_input && p2_place && !game_over && (cnt2 < MAX_PER_PLAYER) &&
                !busy2 && (p1_ok ? ((second_free >= 0) && !same_tile) : (first_free >= 0));
        alloc1 = '0;
        alloc2 = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (p1_ok && (i == first_free)) alloc1[i] = 1'b1;
            if (p2_ok && (i == (p1_ok ? second_free : first_free))) alloc2[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS (FUSE_TICKS),
            .BLAST_TICKS(BLAST_TICKS)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .clear_i   (game_reset),
            .tick_i    (tick),
            .alloc_i   (alloc1[g] | alloc2[g]),
            .owner_i   (alloc2[g]),
            .x_i       (alloc2[g] ? p2_x : p1_x),
            .y_i       (alloc2[g] ? p2_y : p1_y),
            .state_o   (slot_state[g]),
            .owner_o   (slot_owner[g]),
            .x_o       (slot_x[g]),
            .y_o       (slot_y[g]),
            .detonate_o(slot_det[g])
        );
    end

    // Several simultaneous blasts still cost a player only one life.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (slot_det[i]) begin
                if (in_cross(slot_x[i], slot_y[i], p1_x, p1_y)) hit1 = 1'b1;
                if (in_cross(slot_x[i], slot_y[i], p2_x, p2_y)) hit2 = 1'b1;
            end
        end
    end

    always_comb begin
        p1_lives_d = p1_lives_q;
        p2_lives_d = p2_lives_q;
        if (game_reset) begin
            p1_lives_d = START_L;
            p2_lives_d = START_L;
        end else if (tick && !game_over) begin
            if (hit1 && p1_lives_q != '0) p1_lives_d = p1_lives_q - LIVES_W'(1);
            if (hit2 && p2_lives_q != '0) p2_lives_d = p2_lives_q - LIVES_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p1_lives_q <= START_L;
            p2_lives_q <= START_L;
        end else begin
            p1_lives_q <= p1_lives_d;
            p2_lives_q <= p2_lives_d;
        end
    end

    assign p1_lives = p1_lives_q;
    assign p2_lives = p2_lives_q;

    always_comb begin
        bomb_active    = 1'b0;
        bomb_exploding = 1'b0;
        bomb_x         = '0;
        bomb_y         = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (int'(bomb_id) == i) begin
                bomb_active    = (slot_state[i] != SLOT_FREE);
                bomb_exploding = (slot_state[i] == SLOT_BLAST);
                bomb_x         = slot_x[i];
                bomb_y         = slot_y[i];
            end
        end
    end

endmodule

// File: tb/tb_bomb_manager.sv
// Directed bench for bomb_manager: placement arbitration, fuse/blast timing,
// damage, game over, and both reset paths.
module tb_bomb_manager;

    localparam int W = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       game_reset;
    logic       tick;
    logic       read_input;
    logic       p1_place;
    logic       p2_place;
    logic [3:0] p1_x, p1_y, p2_x, p2_y;
    logic [2:0] bomb_id;
    logic       bomb_active;
    logic       bomb_exploding;
    logic [3:0] bomb_x, bomb_y;
    logic [1:0] p1_lives, p2_lives;

    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    bomb_manager dut (
        .clock         (clock),
        .reset         (reset),
        .game_reset    (game_reset),
        .tick          (tick),
        .read_input    (read_input),
        .p1_place      (p1_place),
        .p2_place      (p2_place),
        .p1_x          (p1_x),
        .p1_y          (p1_y),
        .p2_x          (p2_x),
        .p2_y          (p2_y),
        .bomb_id       (bomb_id),
        .bomb_active   (bomb_active),
        .bomb_exploding(bomb_exploding),
        .bomb_x        (bomb_x),
        .bomb_y        (bomb_y),
        .p1_lives      (p1_lives),
        .p2_lives      (p2_lives)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic place(input logic a, input logic b, input logic with_tick);
        read_input = 1'b1;
        p1_place   = a;
        p2_place   = b;
        tick       = with_tick;
        step();
        read_input = 1'b0;
        p1_place   = 1'b0;
        p2_place   = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic do_game_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    task automatic set_p1(input int x, input int y);
        p1_x = 4'(x);
        p1_y = 4'(y);
    endtask

    task automatic set_p2(input int x, input int y);
        p2_x = 4'(x);
        p2_y = 4'(y);
    endtask

    // x < 0 means the coordinates of that slot are not checked.
    task automatic expect_slot(input int id, input logic act, input logic expl,
                               input int x, input int y, input string tag);
        logic [W-1:0] got;
        logic [W-1:0] want;
        logic         chk;
        chk     = (x >= 0);
        bomb_id = 3'(id);
        exp_q.push_back({act, expl, chk ? 4'(x) : 4'd0, chk ? 4'(y) : 4'd0});
        #1;
        got  = {bomb_active, bomb_exploding, chk ? bomb_x : 4'd0, chk ? bomb_y : 4'd0};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_lives(input int l1, input int l2, input string tag);
        logic [W-1:0] got;
        logic [W-1:0] want;
        exp_q.push_back({6'd0, 2'(l1), 2'(l2)});
        #1;
        got  = {6'd0, p1_lives, p2_lives};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        reset      = 1'b1;
        game_reset = 1'b0;
        tick       = 1'b0;
        read_input = 1'b0;
        p1_place   = 1'b0;
        p2_place   = 1'b0;
        set_p1(0, 0);
        set_p2(15, 15);
        bomb_id    = '0;
        repeat (2) @(posedge clock);
        #1;
        expect_slot(0, 0, 0, 0, 0, "reset_hold_slot");
        expect_lives(3, 3, "reset_hold_lives");
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) expect_slot(i, 0, 0, 0, 0, $sformatf("reset_id%0d", i));
        step();
        expect_lives(3, 3, "reset_lives");

        // Single bomb: fuse, blast with damage, free.
        set_p1(2, 2);
        set_p2(5, 5);
        place(1, 0, 0);
        expect_slot(0, 1, 0, 2, 2, "p1_placed");
        do_ticks(7);
        expect_slot(0, 1, 0, 2, 2, "fuse_after7");
        set_p1(2, 3);
        do_ticks(1);
        expect_slot(0, 1, 1, 2, 2, "blast_after8");
        expect_lives(2, 3, "p1_hit");
        do_ticks(1);
        expect_slot(0, 1, 1, 2, 2, "blast_after9");
        do_ticks(1);
        expect_slot(0, 0, 0, -1, -1, "freed_after10");
        expect_lives(2, 3, "no_rehit");

        // Dual placement, then same-tile conflict.
        do_game_reset();
        expect_lives(3, 3, "game_reset_lives");
        expect_slot(0, 0, 0, -1, -1, "game_reset_slot0");
        set_p1(1, 1);
        set_p2(6, 6);
        place(1, 1, 0);
        expect_slot(0, 1, 0, 1, 1, "dual_p1_slot0");
        expect_slot(1, 1, 0, 6, 6, "dual_p2_slot1");
        do_game_reset();
        set_p1(4, 4);
        set_p2(4, 4);
        place(1, 1, 0);
        expect_slot(0, 1, 0, 4, 4, "same_tile_p1");
        expect_slot(1, 0, 0, -1, -1, "same_tile_p2_dropped");

        // Per-player limit and reuse of the lowest free slot.
        do_game_reset();
        set_p2(12, 12);
        set_p1(1, 0);
        place(1, 0, 0);
        do_ticks(1);
        set_p1(3, 0);
        place(1, 0, 0);
        set_p1(5, 0);
        place(1, 0, 0);
        set_p1(7, 0);
        place(1, 0, 0);
        expect_slot(0, 1, 0, 1, 0, "limit_slot0");
        expect_slot(1, 1, 0, 3, 0, "limit_slot1");
        expect_slot(2, 1, 0, 5, 0, "limit_slot2");
        expect_slot(3, 0, 0, -1, -1, "limit_fourth_rejected");
        do_ticks(9);
        expect_slot(0, 0, 0, -1, -1, "limit_first_freed");
        expect_slot(1, 1, 1, 3, 0, "limit_second_blast");
        set_p1(9, 0);
        place(1, 0, 0);
        expect_slot(0, 1, 0, 9, 0, "limit_realloc_lowest");
        expect_slot(3, 0, 0, -1, -1, "limit_slot3_unused");
        expect_lives(3, 3, "limit_lives");

        // Place on a tick cycle, then two blasts on P2 in one tick.
        do_game_reset();
        set_p2(8, 8);
        set_p1(7, 8);
        place(1, 0, 1);
        set_p1(9, 8);
        place(1, 0, 0);
        set_p1(0, 0);
        do_ticks(7);
        expect_slot(0, 1, 0, 7, 8, "tick_place_not_aged");
        do_ticks(1);
        expect_slot(0, 1, 1, 7, 8, "double_blast_a");
        expect_slot(1, 1, 1, 9, 8, "double_blast_b");
        expect_lives(3, 2, "double_hit_one_life");
        do_ticks(2);

        // Drive P2 to zero, then check game-over behaviour.
        set_p1(8, 7);
        place(1, 0, 0);
        do_ticks(1);
        set_p1(8, 9);
        place(1, 0, 0);
        do_ticks(1);
        set_p1(3, 3);
        place(1, 0, 0);
        set_p1(3, 4);
        do_ticks(6);
        expect_lives(3, 1, "p2_second_hit");
        do_ticks(1);
        expect_lives(3, 0, "p2_zero");
        do_ticks(1);
        expect_slot(2, 1, 1, 3, 3, "game_over_still_ages");
        expect_lives(3, 0, "game_over_no_damage");
        set_p1(10, 10);
        place(1, 1, 0);
        expect_slot(0, 0, 0, -1, -1, "game_over_place_rejected");
        do_ticks(1);
        expect_slot(1, 0, 0, -1, -1, "game_over_blast_frees");
        expect_slot(2, 1, 1, 3, 3, "pre_async_reset");

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        expect_slot(2, 0, 0, 0, 0, "async_reset_slot2");
        expect_lives(3, 3, "async_reset_lives");
        step();
        reset = 1'b0;
        step();
        set_p1(1, 1);
        set_p2(5, 5);
        place(1, 1, 0);
        set_p1(1, 3);
        place(1, 0, 0);
        do_ticks(2);
        expect_slot(2, 1, 0, 1, 3, "three_active");
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) expect_slot(i, 0, 0, 0, 0, $sformatf("mid_fuse_reset%0d", i));
        step();
        reset = 1'b0;
        step();

        // game_reset outranks a coincident tick and placement.
        set_p1(2, 2);
        place(1, 0, 0);
        set_p1(6, 2);
        game_reset = 1'b1;
        tick       = 1'b1;
        read_input = 1'b1;
        p1_place   = 1'b1;
        step();
        game_reset = 1'b0;
        tick       = 1'b0;
        read_input = 1'b0;
        p1_place   = 1'b0;
        expect_slot(0, 0, 0, -1, -1, "gr_priority_slot0");
        expect_slot(1, 0, 0, -1, -1, "gr_priority_slot1");
        expect_lives(3, 3, "gr_priority_lives");
        place(1, 0, 0);
        expect_slot(0, 1, 0, 6, 2, "after_gr_place");
        expect_slot(7, 0, 0, 0, 0, "out_of_range_id");

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
